// File: rtl/and_result_collector_if.sv
// -----------------------------------------------------------------------------
// and_result_collector_if
//
// Purpose : Groups the session control, sample input and FIFO read-side
//           signals of and_result_collector into one bundle. clk and rst_n
//           are not part of the bundle and stay plain ports on the block.
//
// Parameters
//   W      : sample width (N1+2 of the collector)
//   CNT_W  : change-counter width
//
// Signals
//   start     : pulse that opens a capture session          (master -> slave)
//   stop      : pulse that closes a capture session         (master -> slave)
//   in_vld    : in_word is valid this cycle                 (master -> slave)
//   in_word   : result word from the gate/mux array, bit 0 = lane 0
//   out_ready : downstream accepts the head entry           (master -> slave)
//   out_vld   : FIFO head entry is valid                    (slave -> master)
//   out_word  : head entry sample                           (slave -> master)
//   out_delta : head entry bit-change mask                  (slave -> master)
//   chg_cnt   : saturating count of detected changes        (slave -> master)
//   ovf       : sticky "change dropped because FIFO full"   (slave -> master)
//   busy      : collector is not idle                       (slave -> master)
// -----------------------------------------------------------------------------
interface and_result_collector_if #(
  parameter int W     = 6,
  parameter int CNT_W = 8
);

  logic             start;
  logic             stop;
  logic             in_vld;
  logic [W-1:0]     in_word;
  logic             out_ready;
  logic             out_vld;
  logic [W-1:0]     out_word;
  logic [W-1:0]     out_delta;
  logic [CNT_W-1:0] chg_cnt;
  logic             ovf;
  logic             busy;

  // Producer/consumer side (testbench or upstream logic).
  modport master (
    output start, stop, in_vld, in_word, out_ready,
    input  out_vld, out_word, out_delta, chg_cnt, ovf, busy
  );

  // Collector side.
  modport slave (
    input  start, stop, in_vld, in_word, out_ready,
    output out_vld, out_word, out_delta, chg_cnt, ovf, busy
  );

endinterface : and_result_collector_if

// File: rtl/and_result_collector.sv
// -----------------------------------------------------------------------------
// and_result_collector
//
// Purpose : Watches the result word of an upstream gate/mux array during a
//           capture session and queues every sample that differs from the
//           previous one (plus the very first sample of a session) together
//           with its bit-change mask. A small FIFO decouples the capture from
//           the downstream reader; changes that find the FIFO full are
//           counted, dropped and flagged with a sticky overflow bit.
//
// Parameters
//   N1    : base width index, sample width W = N1+2
//   DEPTH : FIFO entry count, power of two in 2..16
//   CNT_W : change-counter width (saturating)
//
// Ports
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : and_result_collector_if.slave (start/stop, sample input,
//           FIFO head output with valid/ready, chg_cnt, ovf, busy)
//
// Session flow
//   IDLE    --start-->  CAPTURE  (clears prev, chg_cnt, ovf; arms "first")
//   CAPTURE --stop--->  DRAIN    (a sample on the stop cycle is still taken)
//   DRAIN   --FIFO empty and nothing pushed--> IDLE
// -----------------------------------------------------------------------------
module and_result_collector #(
  parameter int N1    = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and_result_collector_if.slave bus
);

  localparam int W  = N1 + 2;
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CHG_MAX  = '1;
  localparam logic [CNT_W-1:0] CHG_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] word;
    logic [W-1:0] delta;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [W-1:0]     prev_q,    prev_d;
  logic             first_q,   first_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             ovf_q,     ovf_d;
  logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [AW:0]      count_q,   count_d;

  entry_t           mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Per-cycle decode
  // ---------------------------------------------------------------------------
  logic         empty;
  logic         full;
  logic         accept;
  logic [W-1:0] delta;
  logic         change;
  logic         push_req;
  logic         pop;
  logic         push_ok;
  entry_t       head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    // Samples are only looked at while capturing; prev is untouched otherwise.
    accept   = (state_q == CAPTURE) && bus.in_vld;
    delta    = bus.in_word ^ prev_q;
    change   = |delta;
    // The first sample of a session is always queued so the reader gets a
    // reference value even if it happens to equal the cleared prev.
    push_req = accept && (change || first_q);
    pop      = !empty && bus.out_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);
    head     = mem[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous stop, which means nothing in IDLE.
        if (bus.start) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (bus.stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty && !push_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Session registers: prev, first, chg_cnt, ovf
  // ---------------------------------------------------------------------------
  always_comb begin
    prev_d    = prev_q;
    first_d   = first_q;
    chg_cnt_d = chg_cnt_q;
    ovf_d     = ovf_q;

    if ((state_q == IDLE) && bus.start) begin
      prev_d    = '0;
      first_d   = 1'b1;
      chg_cnt_d = '0;
      ovf_d     = 1'b0;
    end

    // accept is only possible in CAPTURE, so it never collides with the
    // session-open clear above.
    if (accept) begin
      prev_d  = bus.in_word;
      first_d = 1'b0;
      // Dropped changes are still counted; the counter sticks at all-ones.
      if (change && (chg_cnt_q != CHG_MAX)) chg_cnt_d = chg_cnt_q + CHG_ONE;
      if (push_req && !push_ok) ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its _d value from before the edge, independent of ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      first_q   <= 1'b0;
      chg_cnt_q <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      first_q   <= first_d;
      chg_cnt_q <= chg_cnt_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is reset instead and the
  // head outputs are forced to zero while empty, so stale contents never
  // reach the outputs.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {bus.in_word, delta};
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from registers, no path from in_word)
  // ---------------------------------------------------------------------------
  assign bus.out_vld   = !empty;
  assign bus.out_word  = empty ? '0 : head.word;
  assign bus.out_delta = empty ? '0 : head.delta;
  assign bus.chg_cnt   = chg_cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q != IDLE);

endmodule : and_result_collector

// File: tb/tb_and_result_collector.sv
// -----------------------------------------------------------------------------
// tb_and_result_collector
//
// Directed scenarios plus randomized sessions for and_result_collector at the
// default parameters (N1=4 -> W=6, DEPTH=4, CNT_W=8). A queue-based reference
// model tracks the session mode, the expected FIFO contents, prev/first,
// the change count and the overflow flag; every clock cycle all outputs are
// compared against it, and the scenarios add fixed expected values on top.
// -----------------------------------------------------------------------------
module tb_and_result_collector;

  localparam int N1      = 4;
  localparam int W       = N1 + 2;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_CAP   = 1;
  localparam int M_DRAIN = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  and_result_collector_if #(.W(W), .CNT_W(CNT_W)) bus ();

  and_result_collector #(
    .N1   (N1),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] delta;
  } entry_t;

  entry_t       m_fifo[$];
  int           m_mode;
  logic [W-1:0] m_prev;
  bit           m_first;
  int           m_cnt;
  bit           m_ovf;

  // Entries the DUT actually handed over (captured on pop cycles).
  entry_t       dut_pops[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_mode  = M_IDLE;
    m_prev  = '0;
    m_first = 1'b0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  // One rising edge of the behaviour, using the inputs currently applied.
  task automatic model_edge();
    int           size0  = m_fifo.size();
    bit           pop    = (size0 != 0) && bus.out_ready;
    bit           pushed = 1'b0;
    entry_t       e;
    logic [W-1:0] d;
    case (m_mode)
      M_IDLE: begin
        if (bus.start) begin
          m_mode  = M_CAP;
          m_prev  = '0;
          m_first = 1'b1;
          m_cnt   = 0;
          m_ovf   = 1'b0;
        end
      end
      M_CAP: begin
        if (bus.in_vld) begin
          d = bus.in_word ^ m_prev;
          if (d != 0 || m_first) begin
            if (size0 < DEPTH || pop) begin
              e.word  = bus.in_word;
              e.delta = d;
              pushed  = 1'b1;
            end else begin
              m_ovf = 1'b1;
            end
          end
          if (d != 0 && m_cnt < CNT_MAX) m_cnt++;
          m_prev  = bus.in_word;
          m_first = 1'b0;
        end
        if (bus.stop) m_mode = M_DRAIN;
      end
      default: begin
        if (size0 == 0) m_mode = M_IDLE;
      end
    endcase
    if (pop)    void'(m_fifo.pop_front());
    if (pushed) m_fifo.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    bit           exp_vld  = (m_fifo.size() != 0);
    logic [W-1:0] exp_word = exp_vld ? m_fifo[0].word  : '0;
    logic [W-1:0] exp_dlt  = exp_vld ? m_fifo[0].delta : '0;
    check({tag, "/out_vld"},   32'(bus.out_vld),   32'(exp_vld));
    check({tag, "/out_word"},  32'(bus.out_word),  32'(exp_word));
    check({tag, "/out_delta"}, 32'(bus.out_delta), 32'(exp_dlt));
    check({tag, "/chg_cnt"},   32'(bus.chg_cnt),   32'(m_cnt));
    check({tag, "/ovf"},       32'(bus.ovf),       32'(m_ovf));
    check({tag, "/busy"},      32'(bus.busy),      32'(m_mode != M_IDLE));
  endtask

  // Inputs are applied just after a rising edge; the model and the pop
  // observation run at the falling edge, outputs are checked 1 after the edge.
  task automatic tick();
    entry_t e;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (bus.out_vld && bus.out_ready) begin
        e.word  = bus.out_word;
        e.delta = bus.out_delta;
        dut_pops.push_back(e);
      end
      model_edge();
    end
    @(posedge clk);
    #1;
    check_outputs("cycle");
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.in_vld    = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  task automatic sample(input logic [W-1:0] w);
    bus.in_vld  = 1'b1;
    bus.in_word = w;
    tick();
    bus.in_vld  = 1'b0;
  endtask

  // Drains the FIFO and waits for IDLE within a cycle budget.
  task automatic wait_idle(input string tag, input int budget);
    bus.out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy && !bus.out_vld) break;
      tick();
    end
    bus.out_ready = 1'b0;
    check({tag, "/idle_reached"}, 32'(bus.busy), 32'(0));
  endtask

  // Hard stop in case something blocks the main sequence.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    #3;
    check("rst/out_vld",   32'(bus.out_vld),   32'(0));
    check("rst/out_word",  32'(bus.out_word),  32'(0));
    check("rst/out_delta", 32'(bus.out_delta), 32'(0));
    check("rst/chg_cnt",   32'(bus.chg_cnt),   32'(0));
    check("rst/ovf",       32'(bus.ovf),       32'(0));
    check("rst/busy",      32'(bus.busy),      32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // ---------------- 15, 15, 14 -> two entries ----------------
    pulse_start();
    check("s1/busy_after_start", 32'(bus.busy), 32'(1));
    sample(6'h15);
    check("s1/latency_out_vld", 32'(bus.out_vld), 32'(1));
    sample(6'h15);
    sample(6'h14);
    check("s1/chg_cnt",    32'(bus.chg_cnt),   32'(2));
    check("s1/head_word",  32'(bus.out_word),  32'(6'h15));
    check("s1/head_delta", 32'(bus.out_delta), 32'(6'h15));
    bus.out_ready = 1'b1;
    tick();
    check("s1/second_word",  32'(bus.out_word),  32'(6'h14));
    check("s1/second_delta", 32'(bus.out_delta), 32'(6'h01));
    tick();
    check("s1/empty_after_two", 32'(bus.out_vld), 32'(0));
    bus.out_ready = 1'b0;
    pulse_stop();
    wait_idle("s1", 10);

    // ---------------- overflow: 6 changes into a 4-deep FIFO ----------------
    pulse_start();
    for (int i = 1; i <= 6; i++) sample(W'(i));
    check("s2/chg_cnt", 32'(bus.chg_cnt), 32'(6));
    check("s2/ovf",     32'(bus.ovf),     32'(1));
    pulse_stop();
    check("s2/ovf_sticky_in_drain", 32'(bus.ovf), 32'(1));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("s2/order_vld",  32'(bus.out_vld),  32'(1));
      check("s2/order_word", 32'(bus.out_word), 32'(k + 1));
      tick();
    end
    check("s2/held_four", 32'(bus.out_vld), 32'(0));
    wait_idle("s2", 10);

    // ---------------- push on full with simultaneous pop ----------------
    pulse_start();
    sample(6'h11);
    sample(6'h22);
    sample(6'h33);
    sample(6'h2A);
    bus.out_ready = 1'b1;
    sample(6'h05);
    bus.out_ready = 1'b0;
    check("s3/ovf",       32'(bus.ovf),      32'(0));
    check("s3/head_word", 32'(bus.out_word), 32'(6'h22));
    pulse_stop();
    dut_pops.delete();
    wait_idle("s3", 12);
    check("s3/occupancy_four", 32'(dut_pops.size()), 32'(4));
    if (dut_pops.size() == 4) begin
      check("s3/last_word",  32'(dut_pops[3].word),  32'(6'h05));
      check("s3/last_delta", 32'(dut_pops[3].delta), 32'(6'h2F));
    end

    // ---------------- stop with 3 queued, in_vld in DRAIN ignored ----------------
    pulse_start();
    sample(6'h01);
    sample(6'h03);
    sample(6'h07);
    pulse_stop();
    check("s4/busy_in_drain", 32'(bus.busy), 32'(1));
    sample(6'h3F);
    sample(6'h00);
    check("s4/chg_cnt_frozen", 32'(bus.chg_cnt), 32'(3));
    dut_pops.delete();
    bus.out_ready = 1'b1;
    tick();
    check("s4/busy_after_pop1", 32'(bus.busy), 32'(1));
    tick();
    check("s4/busy_after_pop2", 32'(bus.busy), 32'(1));
    tick();
    check("s4/empty_after_pop3", 32'(bus.out_vld), 32'(0));
    wait_idle("s4", 4);
    check("s4/pop_count", 32'(dut_pops.size()), 32'(3));
    if (dut_pops.size() == 3) begin
      check("s4/pop0", 32'(dut_pops[0].word), 32'(6'h01));
      check("s4/pop1", 32'(dut_pops[1].word), 32'(6'h03));
      check("s4/pop2", 32'(dut_pops[2].word), 32'(6'h07));
    end

    // ---------------- counter saturation ----------------
    pulse_start();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) sample((i % 2) ? 6'h3F : 6'h00);
    check("s5/chg_cnt_sat", 32'(bus.chg_cnt), 32'(255));
    pulse_stop();
    wait_idle("s5", 10);

    // ---------------- start and stop together in IDLE ----------------
    bus.stop = 1'b1;
    pulse_start();
    bus.stop = 1'b0;
    check("s6/start_wins", 32'(bus.busy), 32'(1));
    sample(6'h2B);
    check("s6/capturing", 32'(bus.out_vld), 32'(1));
    pulse_stop();
    wait_idle("s6", 10);

    // ---------------- randomized sessions ----------------
    for (int s = 0; s < 20; s++) begin
      bus.stop = 1'($urandom_range(0, 1));
      pulse_start();
      bus.stop = 1'b0;
      for (int c = 0; c < 40; c++) begin
        bus.in_vld    = 1'($urandom_range(0, 1));
        bus.in_word   = W'($urandom_range(0, 7));
        bus.out_ready = ($urandom_range(0, 3) == 0);
        bus.start     = ($urandom_range(0, 7) == 0);
        bus.stop      = (c > 30) && ($urandom_range(0, 3) == 0);
        tick();
      end
      idle_inputs();
      pulse_stop();
      wait_idle("rand", 20);
    end

    // ---------------- reset mid-capture ----------------
    pulse_start();
    sample(6'h0A);
    sample(6'h0B);
    check("s7/two_queued", 32'(bus.out_vld), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("s7/rst_out_vld",   32'(bus.out_vld),   32'(0));
    check("s7/rst_out_word",  32'(bus.out_word),  32'(0));
    check("s7/rst_out_delta", 32'(bus.out_delta), 32'(0));
    check("s7/rst_chg_cnt",   32'(bus.chg_cnt),   32'(0));
    check("s7/rst_ovf",       32'(bus.ovf),       32'(0));
    check("s7/rst_busy",      32'(bus.busy),      32'(0));
    tick();
    rst_n = 1'b1;
    bus.in_vld  = 1'b1;
    bus.in_word = 6'h3C;
    tick();
    bus.in_vld  = 1'b0;
    check("s7/waits_for_start", 32'(bus.busy), 32'(0));
    check("s7/contents_gone",   32'(bus.out_vld), 32'(0));
    pulse_start();
    sample(6'h00);
    check("s7/first_pushed", 32'(bus.out_vld),   32'(1));
    check("s7/first_word",   32'(bus.out_word),  32'(6'h00));
    check("s7/first_delta",  32'(bus.out_delta), 32'(6'h00));
    check("s7/first_no_chg", 32'(bus.chg_cnt),   32'(0));
    pulse_stop();
    wait_idle("s7", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_and_result_collector

// File: doc/and_result_collector.md
AND_RESULT_COLLECTOR -- requirements
Module: and_result_collector

Interface
REQ-001 The block SHALL have parameter N1, default 4, which sets the base width index; the sample width W = N1+2 (6 at default).
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the FIFO entry count; it SHALL be a power of two, 2..16.
REQ-003 The block SHALL have parameter CNT_W, default 8, which sets the change-counter width.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  pulse that opens a capture session.
REQ-008 stop  input  1  pulse that closes a capture session.
REQ-009 in_vld  input  1  in_word is valid this cycle.
REQ-010 in_word  input  W  result word from the upstream gate/mux array (bit 0 = lane 0).
REQ-011 out_vld  output  1  FIFO head entry is valid.
REQ-012 out_ready  input  1  downstream accepts the head entry.
REQ-013 out_word  output  W  head entry sample.
REQ-014 out_delta  output  W  head entry bit-change mask.
REQ-015 chg_cnt  output  CNT_W  saturating count of detected changes.
REQ-016 ovf  output  1  sticky flag: a change was dropped because the FIFO was full.
REQ-017 busy  output  1  high when the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE and DRAIN, with transitions: IDLE->CAPTURE on start; CAPTURE->DRAIN on stop; DRAIN->IDLE when the FIFO is empty and no push is occurring.
REQ-019 start SHALL be ignored outside IDLE, and stop SHALL be ignored outside CAPTURE; when start and stop are both high in IDLE, the block SHALL act on start only.
REQ-020 On IDLE->CAPTURE the block SHALL, in the same edge, clear chg_cnt, ovf and prev (a W-bit register), and set the flag first=1.
REQ-021 A sample SHALL be accepted only when state==CAPTURE and in_vld==1; in_vld SHALL be ignored in IDLE and DRAIN, and prev SHALL not be updated in those states.
REQ-022 For an accepted sample: delta = in_word XOR prev; change = (delta != 0); push = change OR first; prev <= in_word; first <= 0.
REQ-023 chg_cnt SHALL increment by 1 on each accepted sample with change=1, including dropped samples, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-024 A push SHALL write {in_word, delta} into the FIFO when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-025 If a push is requested while the FIFO is full and no pop occurs, the sample SHALL be dropped and ovf SHALL be set; ovf SHALL stay set until the next start or reset.
REQ-026 A pop SHALL occur when out_vld AND out_ready are both high; out_vld SHALL equal FIFO not-empty.
REQ-027 out_word and out_delta SHALL present the head entry from registers (no combinational path from in_word).
REQ-028 A push and a pop in the same cycle SHALL leave the occupancy unchanged, including at empty (the pop is not possible at empty) and at full.
REQ-029 Latency: a sample accepted at rising edge k into an empty FIFO SHALL give out_vld=1 after edge k.
REQ-030 The FIFO pointers SHALL wrap modulo DEPTH, and occupancy SHALL be held in a log2(DEPTH)+1 bit counter.
REQ-031 A sample accepted in the same cycle that stop is asserted SHALL still be processed.

Reset
REQ-032 When rst_n is low, the block SHALL immediately set: state=IDLE, FIFO empty, out_vld=0, out_word=0, out_delta=0, chg_cnt=0, ovf=0, busy=0, prev=0, first=0.
REQ-033 A reset asserted mid-session SHALL discard all FIFO contents; after release the block SHALL wait for start.

Verification
REQ-034 The bench SHALL cover: start, then in_word 6'h15 (vld), 6'h15, 6'h14 -> two entries {15,15} and {14,01}; chg_cnt=2.
REQ-035 The bench SHALL cover: out_ready=0 with 6 distinct changing samples at DEPTH=4 -> 4 entries held, ovf=1, chg_cnt=6, and the first 4 samples read out in order.
REQ-036 The bench SHALL cover: FIFO full with out_ready=1 and a changing sample in the same cycle -> push accepted, occupancy stays 4, ovf=0.
REQ-037 The bench SHALL cover: stop with 3 entries queued -> DRAIN, busy=1 until the 3rd pop, then IDLE; in_vld during DRAIN has no effect.
REQ-038 The bench SHALL cover: 300 alternating samples 6'h00/6'h3F with CNT_W=8 -> chg_cnt saturates at 255.
REQ-039 The bench SHALL cover: rst_n pulsed low mid-capture with 2 entries queued -> all outputs 0 immediately; start then 6'h00 -> pushed (first), delta=6'h00.
